// File: rtl/tmds_pkg.sv
// Shared TMDS constants: symbol classes, control/guard-band symbols and the
// disparity counter width used by the encoder stages.
package tmds_pkg;

  localparam int CNT_W = 6;

  localparam logic [1:0] MODE_CTRL  = 2'd0;
  localparam logic [1:0] MODE_DATA  = 2'd1;
  localparam logic [1:0] MODE_GUARD = 2'd2;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_SYM_CH02 = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_CH1  = 10'b0100110011;

  function automatic logic [9:0] ctrl_symbol(input logic [1:0] ctrl);
    logic [9:0] sym;
    case (ctrl)
      2'b00:   sym = CTRL_SYM_00;
      2'b01:   sym = CTRL_SYM_01;
      2'b10:   sym = CTRL_SYM_10;
      default: sym = CTRL_SYM_11;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Number of set bits in an 8-bit word (0..8).
module tmds_popcount8 (
  input  logic [7:0] i_data,
  output logic [3:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < 8; i++) begin
      o_count = o_count + {3'b000, i_data[i]};
    end
  end

endmodule

// File: rtl/tmds_dc_balancer.sv
// TMDS DC-balancing stage: turns a 9-bit q_m word into a 10-bit symbol using a
// running disparity counter, and substitutes control/guard-band symbols.
module tmds_dc_balancer
  import tmds_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [8:0] i_qm,
  input  logic [1:0] i_mode,
  input  logic [1:0] i_ctrl,
  output logic [9:0] o_tmds
);

  localparam logic [9:0] GUARD_SYM = (CHANNEL == 1) ? GUARD_SYM_CH1 : GUARD_SYM_CH02;

  logic [3:0] n1_comb;

  logic [8:0] qm_p1_d, qm_p1_q;
  logic [1:0] mode_p1_d, mode_p1_q;
  logic [1:0] ctrl_p1_d, ctrl_p1_q;
  logic [3:0] n1_p1_d, n1_p1_q;
  logic [3:0] n0_p1_d, n0_p1_q;

  logic [9:0]              tmds_p2_d, tmds_p2_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;

  logic signed [CNT_W-1:0] n1_s, n0_s, q8x2_s, nq8x2_s;

  tmds_popcount8 u_popcount (
    .i_data  (i_qm[7:0]),
    .o_count (n1_comb)
  );

  // Stage 1: capture the word and its ones/zeros counts
  always_comb begin
    qm_p1_d   = i_qm;
    mode_p1_d = i_mode;
    ctrl_p1_d = i_ctrl;
    n1_p1_d   = n1_comb;
    n0_p1_d   = 4'd8 - n1_comb;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      qm_p1_q   <= '0;
      mode_p1_q <= MODE_CTRL;
      ctrl_p1_q <= 2'b00;
      n1_p1_q   <= '0;
      n0_p1_q   <= '0;
    end else begin
      qm_p1_q   <= qm_p1_d;
      mode_p1_q <= mode_p1_d;
      ctrl_p1_q <= ctrl_p1_d;
      n1_p1_q   <= n1_p1_d;
      n0_p1_q   <= n0_p1_d;
    end
  end

  // Stage 2: symbol selection and disparity update from the pre-update cnt
  always_comb begin
    n1_s    = $signed({{(CNT_W-4){1'b0}}, n1_p1_q});
    n0_s    = $signed({{(CNT_W-4){1'b0}}, n0_p1_q});
    q8x2_s  = qm_p1_q[8] ? $signed(CNT_W'(2)) : $signed(CNT_W'(0));
    nq8x2_s = qm_p1_q[8] ? $signed(CNT_W'(0)) : $signed(CNT_W'(2));
    tmds_p2_d = ctrl_symbol(ctrl_p1_q);
    cnt_d     = '0;
    case (mode_p1_q)
      MODE_DATA: begin
        if (cnt_q == 0 || n1_s == n0_s) begin
          tmds_p2_d = {~qm_p1_q[8], qm_p1_q[8], qm_p1_q[8] ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
          cnt_d     = qm_p1_q[8] ? (cnt_q + (n1_s - n0_s)) : (cnt_q + (n0_s - n1_s));
        end else if ((cnt_q > 0 && n1_s > n0_s) || (cnt_q < 0 && n0_s > n1_s)) begin
          tmds_p2_d = {1'b1, qm_p1_q[8], ~qm_p1_q[7:0]};
          cnt_d     = cnt_q + q8x2_s + (n0_s - n1_s);
        end else begin
          tmds_p2_d = {1'b0, qm_p1_q[8], qm_p1_q[7:0]};
          cnt_d     = cnt_q + (n1_s - n0_s) - nq8x2_s;
        end
      end
      MODE_GUARD: tmds_p2_d = GUARD_SYM;
      default:    tmds_p2_d = ctrl_symbol(ctrl_p1_q);
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmds_p2_q <= CTRL_SYM_00;
      cnt_q     <= '0;
    end else begin
      tmds_p2_q <= tmds_p2_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_tmds = tmds_p2_q;

endmodule

// File: tb/tb_tmds_dc_balancer.sv
// Scoreboard bench for tmds_dc_balancer: two lanes (CHANNEL 0 and 1) share
// stimulus; a disparity-based reference model predicts every output symbol.
module tb_tmds_dc_balancer;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] qm;
  logic [1:0] mode;
  logic [1:0] ctrl;
  logic [9:0] tmds0, tmds1;

  always #5 clk = ~clk;

  tmds_dc_balancer #(.CHANNEL(0)) u_dut0 (
    .i_clk (clk), .i_rst (rst), .i_qm (qm), .i_mode (mode), .i_ctrl (ctrl), .o_tmds (tmds0)
  );

  tmds_dc_balancer #(.CHANNEL(1)) u_dut1 (
    .i_clk (clk), .i_rst (rst), .i_qm (qm), .i_mode (mode), .i_ctrl (ctrl), .o_tmds (tmds1)
  );

  typedef struct {
    logic [9:0] e0;
    logic [9:0] e1;
    bit         is_data;
    logic [8:0] qm;
    int         id;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: running disparity and the word waiting in stage 1
  int         mcnt = 0;
  bit         prev_valid = 1'b0;
  logic [8:0] prev_qm = '0;
  logic [1:0] prev_mode = '0;
  logic [1:0] prev_ctrl = '0;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // The model balances by symbol disparity: invert the payload when that
  // pulls the running count back toward zero; the count then moves by the
  // emitted symbol's (ones - zeros).
  task automatic apply(input bit r, input logic [8:0] q, input logic [1:0] m, input logic [1:0] c);
    exp_t e;
    int   dd;
    bit   inv;
    e.is_data = 1'b0;
    e.qm      = prev_qm;
    e.id      = n_vec;
    if (r || !prev_valid) begin
      e.e0 = 10'h354; e.e1 = 10'h354; mcnt = 0;
    end else if (prev_mode == 2'd1) begin
      dd = 2 * $countones(prev_qm[7:0]) - 8;
      if (mcnt == 0 || dd == 0) inv = !prev_qm[8];
      else                      inv = ((mcnt > 0) == (dd > 0));
      e.e0 = {inv, prev_qm[8], inv ? ~prev_qm[7:0] : prev_qm[7:0]};
      e.e1 = e.e0;
      mcnt = mcnt + 2 * $countones(e.e0) - 10;
      e.is_data = 1'b1;
    end else if (prev_mode == 2'd2) begin
      e.e0 = 10'h2CC; e.e1 = 10'h133; mcnt = 0;
    end else begin
      e.e0 = ctrl_sym(prev_ctrl); e.e1 = e.e0; mcnt = 0;
    end
    prev_valid = !r;
    prev_qm    = q;
    prev_mode  = m;
    prev_ctrl  = c;
    rst  = r;
    qm   = q;
    mode = m;
    ctrl = c;
    sbq.push_back(e);
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected symbol per clock, compared mid-cycle
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic [8:0] dec;
      e = sbq.pop_front();
      if (tmds0 !== e.e0) begin
        n_err++;
        $display("FAIL lane0 vec %0d: got 0x%03h want 0x%03h", e.id, tmds0, e.e0);
      end
      if (tmds1 !== e.e1) begin
        n_err++;
        $display("FAIL lane1 vec %0d: got 0x%03h want 0x%03h", e.id, tmds1, e.e1);
      end
      if (e.is_data) begin
        dec = {tmds0[8], tmds0[9] ? ~tmds0[7:0] : tmds0[7:0]};
        if (dec !== e.qm) begin
          n_err++;
          $display("FAIL decode vec %0d: got 0x%03h want 0x%03h", e.id, dec, e.qm);
        end
      end
      if ($signed(u_dut0.cnt_q) > 10 || $signed(u_dut0.cnt_q) < -10) begin
        n_err++;
        $display("FAIL cnt_bound vec %0d: got %0d want |cnt|<=10", e.id, $signed(u_dut0.cnt_q));
      end
      if (mcnt > 10 || mcnt < -10) begin
        n_err++;
        $display("FAIL model_cnt_bound vec %0d: got %0d want |cnt|<=10", e.id, mcnt);
      end
    end
  end

  initial begin
    rst = 1'b1; qm = '0; mode = '0; ctrl = '0;

    // Reset for 3 clocks, then control 01
    repeat (3) apply(1'b1, 9'h000, 2'd0, 2'b00);
    repeat (4) apply(1'b0, 9'h000, 2'd0, 2'b01);

    // Repeated 0x100 data: 0x100, 0x3FF, 0x100, 0x3FF
    repeat (4) apply(1'b0, 9'h100, 2'd1, 2'b00);
    apply(1'b0, 9'h000, 2'd0, 2'b10);

    // 0x0FF twice from cnt 0: 0x200 then 0x0FF
    repeat (2) apply(1'b0, 9'h0FF, 2'd1, 2'b00);

    // Guard band clears disparity; next data word takes case A
    repeat (2) apply(1'b0, 9'h0FF, 2'd2, 2'b00);
    apply(1'b0, 9'h100, 2'd1, 2'b00);
    apply(1'b0, 9'h000, 2'd3, 2'b11);

    // Reset inside a data burst with cnt != 0
    repeat (3) apply(1'b0, 9'h100, 2'd1, 2'b00);
    apply(1'b1, 9'h100, 2'd1, 2'b00);
    repeat (4) apply(1'b0, 9'h0FF, 2'd1, 2'b00);

    // Random soak: mostly data, with mode changes and rare resets
    for (int i = 0; i < 20000; i++) begin
      int sel;
      logic [1:0] m;
      sel = $urandom_range(0, 11);
      if (sel == 0)      m = 2'd0;
      else if (sel == 1) m = 2'd2;
      else if (sel == 2) m = 2'd3;
      else               m = 2'd1;
      apply(($urandom_range(0, 499) == 0), 9'($urandom), m, 2'($urandom));
    end

    repeat (2) apply(1'b0, 9'h000, 2'd0, 2'b00);

    for (int w = 0; w < 10 && sbq.size() > 0; w++) @(posedge clk);
    if (sbq.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
